// File: rtl/mem_sum_sequencer.sv
// Reads DEPTH words from two memories over a shared address bus and accumulates
// dout_a + dout_b into a wrapping sum, tagging each issued address through the read latency.
module mem_sum_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int SUM_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b,
  output logic              busy,
  output logic              done,
  output logic              sum_valid,
  output logic [SUM_W-1:0]  sum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_drain_cnt;
  logic [RD_LAT-1:0]   r_tag;
  logic [SUM_W-1:0]    r_sum;
  logic                r_sum_valid;
  logic                w_accept;
  logic                w_flush;
  logic                w_last_addr;
  logic                w_drain_end;
  logic                w_done;
  logic                w_mem_en;

  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_flush     = abort && (r_state != IDLE);
  assign w_last_addr = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_drain_end = (r_drain_cnt == 2'(RD_LAT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_en     = 1'b0;
    busy         = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_next = READ;
      end
      READ: begin
        w_mem_en = 1'b1;
        if (w_last_addr) w_state_next = DRAIN;
      end
      DRAIN: if (w_drain_end) w_state_next = DONE;
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // A cancel in any active state also suppresses the done pulse of that cycle.
    if (w_flush) begin
      w_state_next = IDLE;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_addr <= '0;
    else if (r_state == READ && !w_flush && !w_last_addr)
      r_addr <= r_addr + ADDR_W'(1);
    else
      r_addr <= '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_drain_cnt <= '0;
    else if (r_state == DRAIN && !w_drain_end && !w_flush)
      r_drain_cnt <= r_drain_cnt + 2'd1;
    else
      r_drain_cnt <= '0;
  end

  // Tag pipeline matches the memory read latency; the top bit marks valid data on dout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag <= '0;
    end else if (w_flush) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_mem_en;
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_accept) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      if (r_tag[RD_LAT-1] && !w_flush)
        r_sum <= r_sum + SUM_W'(dout_a) + SUM_W'(dout_b);
      if (w_done) r_sum_valid <= 1'b1;
    end
  end

  assign mem_en    = w_mem_en;
  assign mem_we    = 1'b0;
  assign mem_addr  = r_addr;
  assign done      = w_done;
  assign sum_valid = r_sum_valid | w_done;
  assign sum       = r_sum;

endmodule

// File: tb/tb_mem_sum_sequencer.sv
// Directed bench for mem_sum_sequencer: three instances (default, SUM_W=7, RD_LAT=2)
// driven in lockstep, each fed by its own behavioural synchronous-read memory pair.
module tb_mem_sum_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [3:0] mem_a [8];
  logic [3:0] mem_b [8];

  logic       mem_en0, mem_we0, busy0, done0, sum_valid0;
  logic       mem_en1, mem_we1, busy1, done1, sum_valid1;
  logic       mem_en2, mem_we2, busy2, done2, sum_valid2;
  logic [2:0] mem_addr0, mem_addr1, mem_addr2;
  logic [7:0] sum0, sum2;
  logic [6:0] sum1;
  logic [3:0] a0_p, b0_p, a1_p, b1_p, a2_p1, b2_p1, a2_p2, b2_p2;

  // Memory models: data from an address appears RD_LAT cycles later, regardless of mem_en.
  always @(posedge clock) begin
    a0_p  <= mem_a[mem_addr0];
    b0_p  <= mem_b[mem_addr0];
    a1_p  <= mem_a[mem_addr1];
    b1_p  <= mem_b[mem_addr1];
    a2_p1 <= mem_a[mem_addr2];
    b2_p1 <= mem_b[mem_addr2];
    a2_p2 <= a2_p1;
    b2_p2 <= b2_p1;
  end

  mem_sum_sequencer dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .dout_a(a0_p), .dout_b(b0_p),
    .busy(busy0), .done(done0), .sum_valid(sum_valid0), .sum(sum0)
  );

  mem_sum_sequencer #(.SUM_W(7)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .dout_a(a1_p), .dout_b(b1_p),
    .busy(busy1), .done(done1), .sum_valid(sum_valid1), .sum(sum1)
  );

  mem_sum_sequencer #(.RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .dout_a(a2_p2), .dout_b(b2_p2),
    .busy(busy2), .done(done2), .sum_valid(sum_valid2), .sum(sum2)
  );

  typedef struct {
    int am;   // A pattern: 0 -> i, 1 -> 15, 2 -> 15-i
    int bm;   // B pattern: 0 -> 1, 1 -> 15, 2 -> 0, 3 -> i
    int e0;   // expected sum, default instance
    int e1;   // expected sum, SUM_W=7
    int e2;   // expected sum, RD_LAT=2
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int am, input int bm);
    for (int i = 0; i < 8; i++) begin
      case (am)
        0:       mem_a[i] = 4'(i);
        1:       mem_a[i] = 4'd15;
        default: mem_a[i] = 4'(15 - i);
      endcase
      case (bm)
        0:       mem_b[i] = 4'd1;
        1:       mem_b[i] = 4'd15;
        2:       mem_b[i] = 4'd0;
        default: mem_b[i] = 4'(i);
      endcase
    end
  endtask

  // One run from a start pulse; with hold=1 start stays high through the DONE cycle.
  task automatic run_vec(input int k, input bit hold);
    int t0;
    int n0 = 0, n1 = 0, n2 = 0;
    int d0 = -1, d1 = -1, d2 = -1;
    int s0 = -1, s1 = -1, s2 = -1;
    int sv0 = -1, addr_err = 0, busy_after = -1;
    fill(tbl[k].am, tbl[k].bm);
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    for (int j = 0; j < 18; j++) begin
      int rel;
      rel = cyc - t0;
      start = hold && (rel <= 10);
      if (rel >= 1 && rel <= 8) begin
        if (!mem_en0 || int'(mem_addr0) != rel - 1) addr_err++;
      end else begin
        if (mem_en0 || mem_addr0 != 3'd0) addr_err++;
      end
      if (done0) begin n0++; d0 = rel; s0 = int'(sum0); sv0 = int'(sum_valid0); end
      if (done1) begin n1++; d1 = rel; s1 = int'(sum1); end
      if (done2) begin n2++; d2 = rel; s2 = int'(sum2); end
      if (rel == 11) busy_after = int'(busy0);
      @(negedge clock);
    end
    start = 1'b0;
    $display("vector %0d hold=%0d: A mode %0d B mode %0d -> sums %0d/%0d/%0d done at +%0d/+%0d/+%0d",
             k, hold, tbl[k].am, tbl[k].bm, s0, s1, s2, d0, d1, d2);
    chk("done_count0", n0, 1);
    chk("done_count1", n1, 1);
    chk("done_count2", n2, 1);
    chk("latency0", d0, 10);
    chk("latency1", d1, 10);
    chk("latency2", d2, 11);
    chk("sum0", s0, tbl[k].e0);
    chk("sum1", s1, tbl[k].e1);
    chk("sum2", s2, tbl[k].e2);
    chk("sum_valid_at_done", sv0, 1);
    chk("addr_sequence_errors", addr_err, 0);
    if (hold) chk("start_in_done_ignored", busy_after, 0);
    chk("sum0_held", int'(sum0), tbl[k].e0);
    chk("sum_valid0_held", int'(sum_valid0), 1);
    chk("sum_valid2_held", int'(sum_valid2), 1);
  endtask

  initial begin
    tbl[0] = '{am: 0, bm: 0, e0: 36,  e1: 36,  e2: 36};
    tbl[1] = '{am: 1, bm: 1, e0: 240, e1: 112, e2: 240};
    tbl[2] = '{am: 0, bm: 2, e0: 28,  e1: 28,  e2: 28};
    tbl[3] = '{am: 2, bm: 3, e0: 120, e1: 120, e2: 120};
    tbl[4] = '{am: 1, bm: 3, e0: 148, e1: 20,  e2: 148};
    fill(0, 0);

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_sum_valid", int'(sum_valid0), 0);
    chk("rst_sum", int'(sum0), 0);
    chk("rst_mem_en", int'(mem_en0), 0);
    chk("rst_mem_addr", int'(mem_addr0), 0);
    chk("rst_mem_we", int'(mem_we0), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int k = 0; k < 5; k++) run_vec(k, 1'b0);

    // start pulsed every cycle of a run
    run_vec(1, 1'b1);

    // start together with abort in IDLE: no run, previous result kept
    begin
      int nd = 0;
      @(negedge clock);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle_busy", int'(busy0), 0);
      chk("start_abort_idle_mem_en", int'(mem_en0), 0);
      for (int j = 0; j < 12; j++) begin
        if (done0 || done2) nd++;
        @(negedge clock);
      end
      $display("start+abort in IDLE: busy=%0d sum=%0d sum_valid=%0d", busy0, sum0, sum_valid0);
      chk("start_abort_idle_done", nd, 0);
      chk("start_abort_idle_sum", int'(sum0), 240);
      chk("start_abort_idle_valid", int'(sum_valid0), 1);
    end

    // abort on the 4th READ cycle
    begin
      int t0;
      int nd = 0;
      fill(0, 0);
      @(negedge clock);
      start = 1'b1;
      t0 = cyc;
      @(negedge clock);
      start = 1'b0;
      while (cyc - t0 < 4) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      $display("abort in READ: busy=%0d mem_en=%0d addr=%0d sum_valid=%0d", busy0, mem_en0, mem_addr0, sum_valid0);
      chk("abort_busy0", int'(busy0), 0);
      chk("abort_busy2", int'(busy2), 0);
      chk("abort_mem_en", int'(mem_en0), 0);
      chk("abort_mem_addr", int'(mem_addr0), 0);
      chk("abort_sum_valid", int'(sum_valid0), 0);
      for (int j = 0; j < 15; j++) begin
        if (done0 || done1 || done2) nd++;
        @(negedge clock);
      end
      chk("abort_no_done", nd, 0);
      chk("abort_sum_valid_later", int'(sum_valid0), 0);
    end
    run_vec(0, 1'b0);

    // reset pulse while in DRAIN
    begin
      int t0;
      int nd = 0;
      fill(1, 1);
      @(negedge clock);
      start = 1'b1;
      t0 = cyc;
      @(negedge clock);
      start = 1'b0;
      while (cyc - t0 < 9) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      $display("reset in DRAIN: busy=%0d sum=%0d sum_valid=%0d done=%0d", busy0, sum0, sum_valid0, done0);
      chk("drain_rst_busy", int'(busy0), 0);
      chk("drain_rst_sum", int'(sum0), 0);
      chk("drain_rst_sum2", int'(sum2), 0);
      chk("drain_rst_sum_valid", int'(sum_valid0), 0);
      chk("drain_rst_done", int'(done0), 0);
      chk("drain_rst_mem_en", int'(mem_en0), 0);
      @(negedge clock);
      reset = 1'b0;
      for (int j = 0; j < 15; j++) begin
        if (done0 || done1 || done2) nd++;
        @(negedge clock);
      end
      chk("drain_rst_no_done", nd, 0);
      chk("drain_rst_sum_after", int'(sum0), 0);
      chk("drain_rst_valid_after", int'(sum_valid2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_sum_sequencer.md
MEM_SUM_SEQUENCER -- requirements
Module: mem_sum_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of words read from each memory per run.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning memory address width (2^ADDR_W >= DEPTH).
REQ-003 SHALL have parameter DATA_W, default 4, meaning memory word width.
REQ-004 SHALL have parameter SUM_W, default 8, meaning accumulator width.
REQ-005 SHALL have parameter RD_LAT, default 1, range 1..3, meaning memory read latency in clock cycles from address to data.
REQ-006 Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle run request.
- abort  input  1  synchronous run cancel.
- mem_en  output  1  enable to both memories.
- mem_we  output  1  write enable to both memories; constant 0.
- mem_addr  output  ADDR_W  shared read address.
- dout_a  input  DATA_W  read data, memory A.
- dout_b  input  DATA_W  read data, memory B.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when sum is final.
- sum_valid  output  1  sum holds a completed result.
- sum  output  SUM_W  accumulated result.

Function
REQ-007 FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-008 IDLE: start=1 and abort=0 -> READ next cycle; sum cleared to 0, sum_valid cleared, mem_addr set to 0.
REQ-009 READ: mem_en=1; mem_addr SHALL increment by 1 each cycle from 0 to DEPTH-1; one address per cycle, no gaps.
REQ-010 READ -> DRAIN on the cycle after address DEPTH-1 is presented; mem_addr returns to 0, mem_en=0.
REQ-011 Internal RD_LAT-deep valid shift register SHALL tag each issued address; when a tag emerges, sum <= sum + dout_a + dout_b (zero-extended to SUM_W).
REQ-012 Exactly DEPTH accumulations per run; no accumulation of data from untagged cycles.
REQ-013 DRAIN lasts RD_LAT cycles, then DONE.
REQ-014 DONE: done=1 for exactly one cycle, sum_valid set to 1, then IDLE.
REQ-015 busy=1 in READ, DRAIN, DONE; 0 in IDLE.
REQ-016 Latency: start accepted at cycle T -> done high at cycle T+DEPTH+RD_LAT+1.
REQ-017 sum and sum_valid SHALL hold steady in IDLE until next accepted start.
REQ-018 Accumulator SHALL wrap modulo 2^SUM_W; no saturation (defaults max 240, no wrap).
REQ-019 start while busy=1 SHALL be ignored, not queued.
REQ-020 abort=1 in READ/DRAIN/DONE -> IDLE next cycle; done not asserted, sum_valid stays 0, pending tags flushed, mem_en=0, mem_addr=0.
REQ-021 start and abort both high in IDLE: abort wins, stay IDLE.
REQ-022 start in the DONE cycle SHALL be ignored; new run accepted earliest the following cycle.
REQ-023 mem_we SHALL be 0 at all times.

Reset
REQ-024 reset=1 SHALL immediately force: IDLE, mem_en=0, mem_addr=0, busy=0, done=0, sum_valid=0, sum=0, tags cleared.
REQ-025 reset asserted mid-run SHALL discard the run; after release no done pulse until a new start.

Verification
REQ-026 A[i]=i, B[i]=1, defaults, start pulse -> addresses 0..7 on consecutive cycles, done at T+10, sum=36, sum_valid=1.
REQ-027 A=B=all 15 -> sum=240; with SUM_W=7 sum=112 (wrap).
REQ-028 abort at 4th READ cycle -> IDLE next cycle, no done, sum_valid=0; fresh start then yields full correct sum.
REQ-029 start pulses every cycle during run -> exactly one done per run, latency unchanged; start+abort in IDLE -> no run.
REQ-030 RD_LAT=2, A[i]=i, B[i]=0 -> done at T+11, sum=28.
REQ-031 reset pulse during DRAIN -> all outputs zero immediately, no done afterwards, sum=0.
